// File: rtl/dnn_pkg.sv
`default_nettype none
// ============================================================================
// Package : dnn_pkg
// Brief   : Shared constants and smoothing-state encoding for the DNN decider.
// Revision: 1.0 - initial release
// ============================================================================
package dnn_pkg;

    localparam int DNN_NUM_CLASSES = 12;
    localparam int DNN_CLS_W       = 4;
    localparam int DNN_SIL_CLASS   = 0;
    localparam int DNN_SCORE_W     = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        LOCKOUT = 2'd2
    } smooth_state_t;

endpackage
`default_nettype wire

// File: rtl/dnn_frame_argmax.sv
`default_nettype none
// ============================================================================
// Module  : dnn_frame_argmax
// Brief   : Streaming argmax over one frame of class scores, with gap timeout.
// Revision: 1.0 - initial release
// ============================================================================
module dnn_frame_argmax
    import dnn_pkg::*;
#(
    parameter int NUM_CLASSES = DNN_NUM_CLASSES,
    parameter int CLS_W       = DNN_CLS_W,
    parameter int GAP_MAX     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DNN_SCORE_W-1:0] vec_in,
    input  logic                   dv_in,
    output logic [CLS_W-1:0]       frame_class,
    output logic [DNN_SCORE_W-1:0] frame_score,
    output logic                   frame_dv,
    output logic                   frame_abort
);

    localparam int c_gap_w = $clog2(GAP_MAX + 1);

    logic [CLS_W-1:0]       r_elem_cnt;
    logic [CLS_W-1:0]       r_max_idx;
    logic [DNN_SCORE_W-1:0] r_max_score;
    logic [c_gap_w-1:0]     r_gap_cnt;

    logic [CLS_W-1:0]       w_next_idx;
    logic [DNN_SCORE_W-1:0] w_next_score;
    logic                   w_last_beat;
    logic                   w_timeout;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_next_idx   = r_max_idx;
        w_next_score = r_max_score;
        if (r_elem_cnt == '0) begin
            w_next_idx   = '0;
            w_next_score = vec_in;
        end else if (vec_in > r_max_score) begin
            w_next_idx   = r_elem_cnt;
            w_next_score = vec_in;
        end
    end

    assign w_last_beat = (r_elem_cnt == CLS_W'(NUM_CLASSES - 1));
    assign w_timeout   = (r_elem_cnt != '0) && (r_gap_cnt == c_gap_w'(GAP_MAX - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_elem_cnt  <= '0;
            r_max_idx   <= '0;
            r_max_score <= '0;
            r_gap_cnt   <= '0;
            frame_class <= '0;
            frame_score <= '0;
            frame_dv    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_dv    <= 1'b0;
            frame_abort <= 1'b0;
            if (dv_in) begin
                r_gap_cnt   <= '0;
                r_max_idx   <= w_next_idx;
                r_max_score <= w_next_score;
                if (w_last_beat) begin
                    frame_dv    <= 1'b1;
                    frame_class <= w_next_idx;
                    frame_score <= w_next_score;
                    r_elem_cnt  <= '0;
                end else begin
                    r_elem_cnt <= r_elem_cnt + 1'b1;
                end
            end else if (r_elem_cnt != '0) begin
                // A beat in the timeout cycle takes the branch above instead.
                if (w_timeout) begin
                    frame_abort <= 1'b1;
                    r_elem_cnt  <= '0;
                    r_gap_cnt   <= '0;
                end else begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dnn_posterior_decider.sv
`default_nettype none
// ============================================================================
// Module  : dnn_posterior_decider
// Brief   : Frame argmax plus run-length smoothing and lockout -> word pulse.
// Revision: 1.0 - initial release
// ============================================================================
module dnn_posterior_decider
    import dnn_pkg::*;
#(
    parameter int                   NUM_CLASSES    = DNN_NUM_CLASSES,
    parameter int                   CLS_W          = DNN_CLS_W,
    parameter int                   SIL_CLASS      = DNN_SIL_CLASS,
    parameter logic [DNN_SCORE_W-1:0] SCORE_THR    = 11'd512,
    parameter int                   HOLD_FRAMES    = 5,
    parameter int                   LOCKOUT_FRAMES = 20,
    parameter int                   GAP_MAX        = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DNN_SCORE_W-1:0] vec_in,
    input  logic                   dv_in,
    output logic [CLS_W-1:0]       frame_class,
    output logic [DNN_SCORE_W-1:0] frame_score,
    output logic                   frame_dv,
    output logic [CLS_W-1:0]       word_id,
    output logic                   word_dv,
    output logic                   frame_abort
);

    localparam int c_run_w  = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam int c_lock_w = (LOCKOUT_FRAMES < 2) ? 1 : $clog2(LOCKOUT_FRAMES + 1);

    smooth_state_t       r_state;
    logic [CLS_W-1:0]    r_run_cls;
    logic [c_run_w-1:0]  r_run_cnt;
    logic [c_lock_w-1:0] r_lock_cnt;

    logic w_qual;
    logic w_fire;

    dnn_frame_argmax #(
        .NUM_CLASSES (NUM_CLASSES),
        .CLS_W       (CLS_W),
        .GAP_MAX     (GAP_MAX)
    ) u_argmax (
        .clk         (clk),
        .reset       (reset),
        .vec_in      (vec_in),
        .dv_in       (dv_in),
        .frame_class (frame_class),
        .frame_score (frame_score),
        .frame_dv    (frame_dv),
        .frame_abort (frame_abort)
    );

    assign w_qual = (frame_class != CLS_W'(SIL_CLASS)) && (frame_score >= SCORE_THR);

    // The run reaches HOLD_FRAMES on this frame.
    always_comb begin
        w_fire = 1'b0;
        if (frame_dv && w_qual) begin
            if (r_state == IDLE)
                w_fire = (HOLD_FRAMES <= 1);
            else if (r_state == TRACK)
                w_fire = (frame_class == r_run_cls) &&
                         (r_run_cnt == c_run_w'(HOLD_FRAMES - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_run_cls  <= '0;
            r_run_cnt  <= '0;
            r_lock_cnt <= '0;
            word_dv    <= 1'b0;
            word_id    <= '0;
        end else begin
            word_dv <= 1'b0;
            if (w_fire) begin
                word_dv    <= 1'b1;
                word_id    <= frame_class;
                r_run_cnt  <= '0;
                r_lock_cnt <= c_lock_w'(LOCKOUT_FRAMES);
                r_state    <= (LOCKOUT_FRAMES > 0) ? LOCKOUT : IDLE;
            end else if (frame_dv) begin
                case (r_state)
                    IDLE: begin
                        if (w_qual) begin
                            r_state   <= TRACK;
                            r_run_cls <= frame_class;
                            r_run_cnt <= c_run_w'(1);
                        end
                    end
                    TRACK: begin
                        if (!w_qual) begin
                            r_state   <= IDLE;
                            r_run_cnt <= '0;
                        end else if (frame_class != r_run_cls) begin
                            r_run_cls <= frame_class;
                            r_run_cnt <= c_run_w'(1);
                        end else begin
                            r_run_cnt <= r_run_cnt + 1'b1;
                        end
                    end
                    LOCKOUT: begin
                        // The frame that exhausts the lockout is not evaluated.
                        r_lock_cnt <= r_lock_cnt - 1'b1;
                        if (r_lock_cnt <= c_lock_w'(1))
                            r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dnn_posterior_decider.sv
`timescale 1ns/1ps
module tb_dnn_posterior_decider;

    localparam int NC   = 12;
    localparam int SIL  = 0;
    localparam int THR  = 512;
    localparam int HOLD = 5;
    localparam int LOCK = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] vec_in = '0;
    logic        dv_in = 1'b0;
    logic [3:0]  frame_class;
    logic [10:0] frame_score;
    logic        frame_dv;
    logic [3:0]  word_id;
    logic        word_dv;
    logic        frame_abort;

    int n_cmp = 0;
    int n_err = 0;
    int n_words = 0;
    int n_frames = 0;
    int last_word_id = 0;

    // Reference model: length of current qualifying run and frames left to ignore.
    int m_run_cls = 0;
    int m_run_len = 0;
    int m_lock_left = 0;

    logic [10:0] fr [NC];

    always #5 clk = ~clk;

    dnn_posterior_decider #(
        .NUM_CLASSES(NC), .CLS_W(4), .SIL_CLASS(SIL), .SCORE_THR(11'd512),
        .HOLD_FRAMES(HOLD), .LOCKOUT_FRAMES(LOCK), .GAP_MAX(64)
    ) dut (
        .clk(clk), .reset(reset), .vec_in(vec_in), .dv_in(dv_in),
        .frame_class(frame_class), .frame_score(frame_score), .frame_dv(frame_dv),
        .word_id(word_id), .word_dv(word_dv), .frame_abort(frame_abort)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_run_cls = 0;
        m_run_len = 0;
        m_lock_left = 0;
    endtask

    task automatic model_step(input int cls, input int sc, output bit fire, output int wid);
        fire = 1'b0;
        wid = 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
        end else if (cls != SIL && sc >= THR) begin
            if (m_run_len > 0 && cls == m_run_cls) m_run_len++;
            else begin
                m_run_cls = cls;
                m_run_len = 1;
            end
            if (m_run_len >= HOLD) begin
                fire = 1'b1;
                wid = cls;
                m_run_len = 0;
                m_lock_left = LOCK;
            end
        end else begin
            m_run_len = 0;
        end
    endtask

    task automatic do_reset();
        dv_in = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic fill_frame(input int win, input int wscore, input int other);
        for (int i = 0; i < NC; i++) fr[i] = 11'(other);
        fr[win] = 11'(wscore);
    endtask

    // Sends fr[] as one frame; stall_len idle cycles are inserted after beat stall_at.
    task automatic send_frame(input int stall_at, input int stall_len, input int max_gap);
        int exp_cls;
        int exp_sc;
        int wid;
        bit fire;
        int idle;
        logic [2:0] seen;
        exp_cls = 0;
        exp_sc = int'(fr[0]);
        for (int i = 1; i < NC; i++)
            if (int'(fr[i]) > exp_sc) begin
                exp_sc = int'(fr[i]);
                exp_cls = i;
            end
        model_step(exp_cls, exp_sc, fire, wid);
        seen = 3'b000;
        for (int i = 0; i < NC; i++) begin
            vec_in = fr[i];
            dv_in = 1'b1;
            tick();
            dv_in = 1'b0;
            vec_in = 11'($urandom);
            if (i < NC - 1) begin
                seen |= {frame_dv, frame_abort, word_dv};
                idle = (i == stall_at) ? stall_len : int'($urandom_range(0, max_gap));
                repeat (idle) begin
                    tick();
                    seen |= {frame_dv, frame_abort, word_dv};
                end
            end
        end
        n_cmp++;
        if (seen !== 3'b000) begin
            n_err++;
            $display("FAIL mid_frame_pulses: got %b want 000", seen);
        end
        n_cmp++;
        if ({frame_dv, frame_abort, word_dv} !== 3'b100) begin
            n_err++;
            $display("FAIL frame_dv_latency: dv/abort/word got %b want 100", {frame_dv, frame_abort, word_dv});
        end
        n_cmp++;
        if (frame_class !== 4'(exp_cls) || frame_score !== 11'(exp_sc)) begin
            n_err++;
            $display("FAIL frame_result: got cls %0d sc %0d want cls %0d sc %0d",
                     frame_class, frame_score, exp_cls, exp_sc);
        end
        n_frames++;
        tick();
        n_cmp++;
        if (word_dv !== fire || frame_dv !== 1'b0) begin
            n_err++;
            $display("FAIL word_dv: got word_dv %b frame_dv %b want %b 0", word_dv, frame_dv, fire);
        end
        if (fire) begin
            n_cmp++;
            if (word_id !== 4'(wid)) begin
                n_err++;
                $display("FAIL word_id: got %0d want %0d", word_id, wid);
            end
        end
        n_cmp++;
        if (frame_class !== 4'(exp_cls) || frame_score !== 11'(exp_sc)) begin
            n_err++;
            $display("FAIL frame_hold: got cls %0d sc %0d want cls %0d sc %0d",
                     frame_class, frame_score, exp_cls, exp_sc);
        end
        if (word_dv === 1'b1) begin
            n_words++;
            last_word_id = int'(word_id);
        end
    endtask

    task automatic test_reset();
        logic [2:0] seen;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dv_in = 1'($urandom);
            vec_in = 11'($urandom);
            tick();
            n_cmp++;
            if ({frame_class, frame_score, frame_dv, word_id, word_dv, frame_abort} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got cls %0d sc %0d fdv %b wid %0d wdv %b ab %b want all 0",
                         frame_class, frame_score, frame_dv, word_id, word_dv, frame_abort);
            end
        end
        dv_in = 1'b0;
        reset = 1'b1;
        model_reset();
        seen = 3'b000;
        repeat (20) begin
            tick();
            seen |= {frame_dv, frame_abort, word_dv};
        end
        n_cmp++;
        if (seen !== 3'b000) begin
            n_err++;
            $display("FAIL post_reset_quiet: got %b want 000", seen);
        end
    endtask

    task automatic test_argmax_ties();
        do_reset();
        for (int i = 0; i < NC; i++) fr[i] = 11'd0;
        fr[0] = 11'd100;
        fr[1] = 11'd700;
        fr[2] = 11'd700;
        fr[3] = 11'd300;
        send_frame(-1, 0, 0);
        n_cmp++;
        if (frame_class !== 4'd1 || frame_score !== 11'd700) begin
            n_err++;
            $display("FAIL argmax_tie: got cls %0d sc %0d want cls 1 sc 700", frame_class, frame_score);
        end
    endtask

    task automatic test_detection();
        do_reset();
        n_words = 0;
        fill_frame(3, 800, 50);
        for (int f = 0; f < 6; f++) send_frame(-1, 0, 3);
        n_cmp++;
        if (n_words !== 1 || last_word_id !== 3) begin
            n_err++;
            $display("FAIL detection: got %0d words id %0d want 1 words id 3", n_words, last_word_id);
        end
    endtask

    task automatic test_run_break_lockout();
        do_reset();
        n_words = 0;
        fill_frame(3, 800, 10);
        for (int f = 0; f < 4; f++) send_frame(-1, 0, 1);
        fill_frame(5, 900, 10);
        for (int f = 0; f < 5; f++) send_frame(-1, 0, 1);
        n_cmp++;
        if (n_words !== 1 || last_word_id !== 5) begin
            n_err++;
            $display("FAIL run_break: got %0d words id %0d want 1 words id 5", n_words, last_word_id);
        end
        for (int f = 0; f < 24; f++) send_frame(-1, 0, 1);
        n_cmp++;
        if (n_words !== 1) begin
            n_err++;
            $display("FAIL lockout: got %0d words want 1", n_words);
        end
        send_frame(-1, 0, 1);
        n_cmp++;
        if (n_words !== 2) begin
            n_err++;
            $display("FAIL post_lockout_run: got %0d words want 2", n_words);
        end
    endtask

    task automatic test_threshold_silence();
        int f0;
        do_reset();
        n_words = 0;
        f0 = n_frames;
        fill_frame(0, 1000, 20);
        for (int f = 0; f < 10; f++) send_frame(-1, 0, 2);
        fill_frame(4, 511, 20);
        for (int f = 0; f < 10; f++) send_frame(-1, 0, 2);
        n_cmp++;
        if (n_words !== 0 || n_frames - f0 !== 20) begin
            n_err++;
            $display("FAIL thr_silence: got %0d words %0d frames want 0 words 20 frames",
                     n_words, n_frames - f0);
        end
    endtask

    task automatic test_gap_abort();
        logic [2:0] seen;
        do_reset();
        seen = 3'b000;
        for (int i = 0; i < 6; i++) begin
            vec_in = 11'($urandom);
            dv_in = 1'b1;
            tick();
            dv_in = 1'b0;
            seen |= {frame_dv, frame_abort, word_dv};
        end
        repeat (63) begin
            tick();
            seen |= {frame_dv, frame_abort, word_dv};
        end
        n_cmp++;
        if (seen !== 3'b000) begin
            n_err++;
            $display("FAIL gap_early: got %b want 000", seen);
        end
        tick();
        n_cmp++;
        if (frame_abort !== 1'b1 || frame_dv !== 1'b0) begin
            n_err++;
            $display("FAIL gap_abort: got abort %b fdv %b want 1 0", frame_abort, frame_dv);
        end
        tick();
        n_cmp++;
        if (frame_abort !== 1'b0) begin
            n_err++;
            $display("FAIL abort_width: got %b want 0", frame_abort);
        end
        fill_frame(7, 600, 30);
        send_frame(-1, 0, 2);
        // Beat lands on the 64th idle cycle: counted, frame still completes.
        fill_frame(9, 650, 40);
        send_frame(5, 63, 0);
        seen = 3'b000;
        for (int i = 0; i < 5; i++) begin
            vec_in = 11'd2000;
            dv_in = 1'b1;
            tick();
        end
        dv_in = 1'b0;
        reset = 1'b0;
        #1;
        seen |= {frame_dv, frame_abort, word_dv};
        repeat (3) begin
            tick();
            seen |= {frame_dv, frame_abort, word_dv};
        end
        reset = 1'b1;
        model_reset();
        repeat (70) begin
            tick();
            seen |= {frame_dv, frame_abort, word_dv};
        end
        n_cmp++;
        if (seen !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid_frame: got %b want 000", seen);
        end
        fill_frame(2, 777, 100);
        send_frame(-1, 0, 1);
    endtask

    task automatic test_random();
        int win;
        int ws;
        do_reset();
        for (int f = 0; f < 60; f++) begin
            win = int'($urandom_range(0, 3));
            ws = int'($urandom_range(450, 2047));
            for (int i = 0; i < NC; i++) fr[i] = 11'($urandom_range(0, ws));
            fr[win] = 11'(ws);
            send_frame(-1, 0, 2);
        end
    endtask

    initial begin
        test_reset();
        test_argmax_ties();
        test_detection();
        test_run_break_lockout();
        test_threshold_silence();
        test_gap_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dnn_posterior_decider.md
Name: dnn_posterior_decider

Overview:
Downstream stage of the word-detect DNN. It consumes the DNN's per-class output scores, streamed one 11-bit score per dv_in beat. For each frame it finds the winning class (argmax), then applies run-length smoothing and a post-detection lockout. The result is a single word-detect pulse per spoken word, delivered to the control/display logic.

Parameters:
NUM_CLASSES, 12, score beats per frame (class index 0..NUM_CLASSES-1)
CLS_W, 4, width of class index; must satisfy 2**CLS_W >= NUM_CLASSES
SIL_CLASS, 0, class index treated as silence/garbage, never reported as a word
SCORE_THR, 11'd512, minimum winning score for a frame to count toward a run
HOLD_FRAMES, 5, consecutive qualifying frames of the same class needed to fire
LOCKOUT_FRAMES, 20, frames ignored after a detection
GAP_MAX, 64, max idle cycles between beats inside a frame before the partial frame is aborted

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
vec_in  in  11  DNN class score, unsigned, class order 0..NUM_CLASSES-1
dv_in  in  1  score valid, one beat per class
frame_class  out  CLS_W  argmax class of the last complete frame
frame_score  out  11  winning score of the last complete frame
frame_dv  out  1  one-cycle pulse; frame_class/frame_score valid
word_id  out  CLS_W  detected word class
word_dv  out  1  one-cycle pulse on detection
frame_abort  out  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset (async, active-low): all outputs 0; element counter, run counter, lockout counter and gap counter cleared; state IDLE.
- Argmax:
  - elem_cnt counts dv_in beats.
  - Beat 0 loads max_score=vec_in and max_idx=0.
  - Later beats replace the max only if vec_in > max_score (strict), so ties go to the lowest index.
- Frame completion:
  - The beat with elem_cnt==NUM_CLASSES-1 completes the frame.
  - On the next cycle frame_dv=1 with the final argmax (latency 1 clock from the last beat); elem_cnt wraps to 0.
  - frame_class/frame_score hold their values until the next frame_dv.
- Gap timeout:
  - gap_cnt counts cycles with dv_in=0 while elem_cnt!=0 and resets on each beat.
  - Reaching GAP_MAX pulses frame_abort for 1 cycle, clears elem_cnt and leaves the smoothing state untouched.
  - A beat arriving in the same cycle as the timeout wins: it is counted and no abort occurs.
- Qualifying frame: class!=SIL_CLASS and score>=SCORE_THR.
- Smoothing FSM (evaluated in the cycle frame_dv is asserted):
  - IDLE: a qualifying frame goes to TRACK with run_cls=class, run_cnt=1. Otherwise stay in IDLE.
  - TRACK, qualifying frame with class==run_cls: run_cnt++. If run_cnt reaches HOLD_FRAMES, word_dv pulses in the next cycle with word_id=run_cls, then go to LOCKOUT with lock_cnt=LOCKOUT_FRAMES.
  - TRACK, qualifying frame with a different class: restart the run (run_cls=class, run_cnt=1).
  - TRACK, non-qualifying frame: go to IDLE, run_cnt=0.
  - LOCKOUT: each frame_dv decrements lock_cnt. The frame that takes lock_cnt to 0 returns the FSM to IDLE; that frame is not evaluated.
  - frame_abort never changes the FSM state.
- HOLD_FRAMES=1: the first qualifying frame fires directly from IDLE.
- Latency: last score beat to word_dv = 2 clocks.
- Input rate:
  - dv_in may be asserted on consecutive cycles or sparsely; no backpressure.
  - The DNN cadence is 1 beat per 21 cycles, well under GAP_MAX.
- Reset mid-frame discards the partial frame with no frame_dv or frame_abort pulse.

Decomposition:
- Shared package (dnn_pkg): NUM_CLASSES, CLS_W, SIL_CLASS, score width 11, and the FSM state encoding IDLE/TRACK/LOCKOUT.
- One sub-module, dnn_frame_argmax: elem_cnt, gap timer, running max, frame_dv and frame_abort.
- The top holds the smoothing FSM and its counters.

Test Plan:
1. Reset: hold reset=0 for 5 cycles with random dv_in -> all outputs 0; release -> no pulses until a full frame arrives.
2. Argmax and ties: one frame of scores {100,700,700,300,0...} -> frame_dv 1 cycle after beat 11, frame_class=1, frame_score=700.
3. Detection: 5 frames with class 3 at score 800 -> word_dv=1 with word_id=3 exactly 2 cycles after the 5th frame's last beat; a 6th identical frame gives no pulse.
4. Run break and lockout:
   - Class 3 ×4, then class 5 ×5 -> word_id=5 once.
   - Then class 5 ×20 -> no word_dv.
   - The 21st-onward qualifying class-5 frames need 5 more to fire.
5. Threshold and silence: 10 frames of class 0 at 1000, then class 4 at 511 -> no word_dv; frame_dv on every frame.
6. Gap abort: 6 beats, then 64 idle cycles -> frame_abort pulse, no frame_dv; the next 12 beats yield a normal frame; reset asserted mid-frame -> no pulses.
